// File: rtl/spi_axil_regs.sv
// AXI4-Lite register front end for an SPI master: configuration and timing
// registers, TX/RX data words, sticky status flags, and the small FSM that
// pulses start_o until the master acknowledges with busy_i.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | no frame in flight; config writable, TXDATA write starts one
// ST_PEND   | start_o toggling until busy_i rises or the timeout expires
// ST_ACTIVE | master busy; on busy_i low capture the RX word, set done
module spi_axil_regs #(
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 255
) (
    input  logic              GCLK,
    input  logic              RST,

    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,

    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,

    output logic              start_o,
    input  logic              busy_i,
    output logic [1:0]        spi_mode_o,
    output logic [1:0]        sck_speed_o,
    output logic [1:0]        word_len_o,
    output logic [7:0]        t_IFG_o,
    output logic [7:0]        t_CS_SCK_o,
    output logic [7:0]        t_SCK_CS_o,
    output logic [31:0]       mosi_data_o,
    input  logic [31:0]       miso_data_i,
    output logic              irq_o
);

    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(32'h00);
    localparam logic [ADDR_W-1:0] A_TIMING = ADDR_W'(32'h04);
    localparam logic [ADDR_W-1:0] A_TXDATA = ADDR_W'(32'h08);
    localparam logic [ADDR_W-1:0] A_RXDATA = ADDR_W'(32'h0C);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(32'h10);

    // PEND lasts exactly TIMEOUT cycles: the abandon decision is taken in
    // the cycle where the counter shows TIMEOUT-1 elapsed cycles.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] TMO_SAT  = 8'(TIMEOUT);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PEND   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    function automatic logic is_mapped(input logic [ADDR_W-1:0] a);
        return (a == A_CTRL) || (a == A_TIMING) || (a == A_TXDATA) ||
               (a == A_RXDATA) || (a == A_STATUS);
    endfunction

    state_t      state;
    state_t      state_nxt;
    logic        phase;
    logic [7:0]  tmo_cnt;
    logic        tmo_set;
    logic        rx_cap;

    logic [1:0]  mode_q;
    logic [1:0]  speed_q;
    logic [1:0]  wlen_q;
    logic        irq_en_q;
    logic [7:0]  t_ifg_q;
    logic [7:0]  t_cs_sck_q;
    logic [7:0]  t_sck_cs_q;
    logic [31:0] tx_q;
    logic [31:0] rx_q;
    logic        done_q;
    logic        ovr_q;
    logic        tmo_q;

    logic        wr_hs;
    logic        rd_hs;
    logic        fsm_idle;
    logic        sel_ctrl;
    logic        sel_timing;
    logic        sel_tx;
    logic        sel_status;
    logic        wr_err;
    logic        ctrl_we;
    logic        timing_we;
    logic        tx_start;
    logic        tx_ovr;
    logic        status_we;
    logic        rx_read;
    logic [31:0] rd_data;
    logic        rd_err;
    logic        unused_wstrb;

    // Byte enables are not honoured; every write updates whole fields.
    assign unused_wstrb = ^s_axi_wstrb;

    // Ready strobes are combinational and gated by reset so they read 0
    // while RST is low regardless of what the master drives.
    assign wr_hs = RST & s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid;
    assign rd_hs = RST & s_axi_arvalid & ~s_axi_rvalid;

    assign s_axi_awready = wr_hs;
    assign s_axi_wready  = wr_hs;
    assign s_axi_arready = rd_hs;

    assign fsm_idle   = (state == ST_IDLE);
    assign sel_ctrl   = (s_axi_awaddr == A_CTRL);
    assign sel_timing = (s_axi_awaddr == A_TIMING);
    assign sel_tx     = (s_axi_awaddr == A_TXDATA);
    assign sel_status = (s_axi_awaddr == A_STATUS);

    // Config is frozen while a frame is in flight; such writes are refused.
    assign wr_err    = ~is_mapped(s_axi_awaddr) | ((sel_ctrl | sel_timing) & ~fsm_idle);
    assign ctrl_we   = wr_hs & sel_ctrl & fsm_idle;
    assign timing_we = wr_hs & sel_timing & fsm_idle;
    assign tx_start  = wr_hs & sel_tx & fsm_idle;
    assign tx_ovr    = wr_hs & sel_tx & ~fsm_idle;
    assign status_we = wr_hs & sel_status;
    assign rx_read   = rd_hs & (s_axi_araddr == A_RXDATA);

    assign spi_mode_o  = mode_q;
    assign sck_speed_o = speed_q;
    assign word_len_o  = wlen_q;
    assign t_IFG_o     = t_ifg_q;
    assign t_CS_SCK_o  = t_cs_sck_q;
    assign t_SCK_CS_o  = t_sck_cs_q;
    assign mosi_data_o = tx_q;

    // Transfer FSM state register plus the PEND toggle phase and timeout count.
    always_ff @(posedge GCLK or negedge RST) begin
        if (!RST) begin
            state   <= ST_IDLE;
            phase   <= 1'b0;
            tmo_cnt <= 8'd0;
        end else begin
            state <= state_nxt;
            if (state != ST_PEND) begin
                phase   <= 1'b0;
                tmo_cnt <= 8'd0;
            end else begin
                phase <= ~phase;
                if (tmo_cnt != TMO_SAT) begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                end
            end
        end
    end

    // Next-state logic; start_o drops in the same cycle busy_i is seen.
    always_comb begin
        state_nxt = state;
        start_o   = 1'b0;
        tmo_set   = 1'b0;
        rx_cap    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tx_start) begin
                    state_nxt = ST_PEND;
                end
            end
            ST_PEND: begin
                start_o = ~phase & ~busy_i;
                if (busy_i) begin
                    state_nxt = ST_ACTIVE;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_set   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (!busy_i) begin
                    rx_cap    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // CTRL / TIMING configuration registers.
    always_ff @(posedge GCLK or negedge RST) begin
        if (!RST) begin
            mode_q     <= 2'd0;
            speed_q    <= 2'd0;
            wlen_q     <= 2'd0;
            irq_en_q   <= 1'b0;
            t_ifg_q    <= 8'd0;
            t_cs_sck_q <= 8'd0;
            t_sck_cs_q <= 8'd0;
        end else begin
            if (ctrl_we) begin
                mode_q   <= s_axi_wdata[1:0];
                speed_q  <= s_axi_wdata[3:2];
                wlen_q   <= s_axi_wdata[5:4];
                irq_en_q <= s_axi_wdata[8];
            end
            if (timing_we) begin
                t_ifg_q    <= s_axi_wdata[7:0];
                t_cs_sck_q <= s_axi_wdata[15:8];
                t_sck_cs_q <= s_axi_wdata[23:16];
            end
        end
    end

    // TX/RX data words and sticky status flags; a set beats a clear.
    always_ff @(posedge GCLK or negedge RST) begin
        if (!RST) begin
            tx_q   <= 32'd0;
            rx_q   <= 32'd0;
            done_q <= 1'b0;
            ovr_q  <= 1'b0;
            tmo_q  <= 1'b0;
        end else begin
            if (tx_start) begin
                tx_q <= s_axi_wdata;
            end
            if (rx_cap) begin
                rx_q <= miso_data_i;
            end

            if (rx_cap) begin
                done_q <= 1'b1;
            end else if (tx_start || rx_read) begin
                done_q <= 1'b0;
            end

            if (tx_ovr) begin
                ovr_q <= 1'b1;
            end else if (status_we && s_axi_wdata[2]) begin
                ovr_q <= 1'b0;
            end

            if (tmo_set) begin
                tmo_q <= 1'b1;
            end else if (status_we && s_axi_wdata[3]) begin
                tmo_q <= 1'b0;
            end
        end
    end

    // Completion interrupt, one cycle behind done.
    always_ff @(posedge GCLK or negedge RST) begin
        if (!RST) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= done_q & irq_en_q;
        end
    end

    // Write response channel.
    always_ff @(posedge GCLK or negedge RST) begin
        if (!RST) begin
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
        end else if (wr_hs) begin
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
        end else if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
        end
    end

    // Read data mux; unmapped addresses return zero with an error flag.
    always_comb begin
        rd_data = 32'd0;
        rd_err  = 1'b0;
        case (s_axi_araddr)
            A_CTRL:   rd_data = {23'd0, irq_en_q, 2'b00, wlen_q, speed_q, mode_q};
            A_TIMING: rd_data = {8'd0, t_sck_cs_q, t_cs_sck_q, t_ifg_q};
            A_TXDATA: rd_data = 32'd0;
            A_RXDATA: rd_data = rx_q;
            A_STATUS: rd_data = {28'd0, tmo_q, ovr_q, done_q, ~fsm_idle};
            default:  rd_err  = 1'b1;
        endcase
    end

    // Read response channel; data held stable until accepted.
    always_ff @(posedge GCLK or negedge RST) begin
        if (!RST) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= 32'd0;
            s_axi_rresp  <= RESP_OKAY;
        end else if (rd_hs) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= rd_data;
            s_axi_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
        end else if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
        end
    end

endmodule

// File: doc/spi_axil_regs.md
SPI_AXIL_REGS -- requirements
Module: spi_axil_regs

Interface
REQ-001 SHALL have parameter ADDR_W, default 5: AXI4-Lite byte-address width.
REQ-002 SHALL have parameter TIMEOUT, default 255: PEND cycles before a start attempt is abandoned.
REQ-003 Clock and reset, which SHALL be listed first:
- GCLK  in  1  single clock; all logic on rising edge.
- RST  in  1  reset, asynchronous, active-low.
REQ-004 AXI4-Lite write ports SHALL be:
- s_axi_awaddr  in  ADDR_W
- s_axi_awvalid  in  1
- s_axi_awready  out  1
- s_axi_wdata  in  32
- s_axi_wstrb  in  4  (ignored)
- s_axi_wvalid  in  1
- s_axi_wready  out  1
- s_axi_bresp  out  2
- s_axi_bvalid  out  1
- s_axi_bready  in  1
REQ-005 AXI4-Lite read ports SHALL be:
- s_axi_araddr  in  ADDR_W
- s_axi_arvalid  in  1
- s_axi_arready  out  1
- s_axi_rdata  out  32
- s_axi_rresp  out  2
- s_axi_rvalid  out  1
- s_axi_rready  in  1
REQ-006 SPI-master-facing ports SHALL be:
- start_o  out  1  start request
- busy_i  in  1  master busy
- spi_mode_o, sck_speed_o, word_len_o  out  2 each
- t_IFG_o, t_CS_SCK_o, t_SCK_CS_o  out  8 each
- mosi_data_o  out  32  TX word
- miso_data_i  in  32  RX word
- irq_o  out  1  completion interrupt

Function
REQ-007 The register map SHALL be:
- 0x00 CTRL RW: [1:0] mode, [3:2] speed, [5:4] word_len, [8] irq_en.
- 0x04 TIMING RW: [7:0] t_IFG, [15:8] t_CS_SCK, [23:16] t_SCK_CS.
- 0x08 TXDATA WO: reads return 0.
- 0x0C RXDATA RO.
- 0x10 STATUS: [0] busy RO, [1] done, [2] overrun W1C, [3] timeout W1C.
- Unused bits read 0.
REQ-008 The write path SHALL assert awready and wready together for one cycle only when awvalid, wvalid and !bvalid are all true.
REQ-009 bvalid SHALL rise the cycle after the AW/W handshake and hold until bready.
REQ-010 The read path SHALL assert arready for one cycle when arvalid and !rvalid.
REQ-011 rvalid, rdata and rresp SHALL be registered the cycle after the AR handshake and held stable until rready.
REQ-012 An unmapped address SHALL return resp 2'b10 (SLVERR), read data 0, and no state change; all other accesses SHALL return 2'b00.
REQ-013 CTRL/TIMING writes while the transfer FSM is not IDLE SHALL be ignored and return SLVERR, so config is frozen during a frame.
REQ-014 The transfer FSM SHALL have states IDLE, PEND and ACTIVE.
REQ-015 In IDLE, a TXDATA write SHALL latch wdata into mosi_data_o, clear done, and move to PEND the next cycle.
REQ-016 In PEND, start_o SHALL toggle every cycle starting at 1, giving a rising edge every 2 cycles, so that the master's edge detector re-triggers once its IFG expires.
REQ-017 In PEND, busy_i=1 SHALL move the FSM to ACTIVE with start_o=0 the same cycle.
REQ-018 In PEND, TIMEOUT cycles without busy_i SHALL set timeout and return the FSM to IDLE with start_o=0.
REQ-019 In ACTIVE, busy_i=0 SHALL capture miso_data_i into RXDATA, set done, and return the FSM to IDLE.
REQ-020 A TXDATA write in PEND or ACTIVE SHALL set overrun, leave mosi_data_o unchanged and return OKAY.
REQ-021 done SHALL clear on the RXDATA read handshake; if set and clear occur in the same cycle, set SHALL win.
REQ-022 STATUS.busy SHALL read 1 whenever the FSM is not IDLE.
REQ-023 irq_o SHALL be registered as done & irq_en.
REQ-024 The timeout counter SHALL be 8 bits, SHALL saturate at TIMEOUT, and SHALL clear on PEND entry.

Reset
REQ-025 While RST=0, all outputs SHALL be 0: every ready/valid, start_o, irq_o, and all config and data outputs.
REQ-026 While RST=0, the FSM SHALL be IDLE and all register fields SHALL be 0.
REQ-027 Reset mid-frame SHALL abandon the transfer immediately, including any pending AXI response.
REQ-028 After RST rises, the block SHALL accept a new access on the first clock edge.

Verification
REQ-029 Write CTRL=0x0000013 then read it back -> rdata 0x00000013, spi_mode_o=3, sck_speed_o=0, word_len_o=1, resp OKAY.
REQ-030 Write TXDATA=0xA5A5_0F0F; model busy_i high 3 cycles after PEND entry, low 40 cycles later with miso_data_i=0x1234_5678 -> start_o toggles until busy_i, then RXDATA=0x12345678, done=1, irq_o=1 when irq_en=1.
REQ-031 Write TXDATA twice back-to-back -> second write sets overrun, mosi_data_o stays at the first value, and writing STATUS=0x4 clears overrun.
REQ-032 Hold busy_i=0 after a TXDATA write -> timeout=1 after 255 PEND cycles, FSM returns to IDLE, start_o=0.
REQ-033 Read 0x1C -> SLVERR with rdata 0; write TIMING during ACTIVE -> SLVERR and t_IFG_o unchanged.
REQ-034 Hold bready=0 for 10 cycles after a write -> bvalid stays high, awready stays 0, and a second write is accepted only after bready.
